// File: rtl/fsm_pkg.sv
// Shared state encodings and sizing helper for the serial bit feeder.
// No logic; constant definitions only.
package fsm_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic int CNT_W(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Word-load handshake plus serial bit output bundle of the bit feeder.
// slave = feeder side, master = upstream producer / downstream detector side.
interface serial_bit_feeder_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             shift_en;
   logic             x_out;
   logic             x_valid;
   logic             busy;
   logic             done;

   modport slave (
      input  load_valid, load_data, shift_en,
      output load_ready, x_out, x_valid, busy, done
   );

   modport master (
      output load_valid, load_data, shift_en,
      input  load_ready, x_out, x_valid, busy, done
   );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-load shift register; serial bit comes straight off a flop.
// Zero-latency load, shifts one bit per shift strobe; clear has priority over load.
module piso_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic             ser_out
);
   logic [WIDTH-1:0] sreg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sreg <= '0;
      end else if (clr) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= data;
      end else if (shift) begin
         // Move toward the output end, back-filling with zero.
         if (MSB_FIRST) sreg <= {sreg[WIDTH-2:0], 1'b0};
         else           sreg <= {1'b0, sreg[WIDTH-1:1]};
      end
   end

   assign ser_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/serial_bit_feeder.sv
// Serializes WIDTH-bit words onto x_out, one bit per shift_en edge; first bit visible the edge after accept.
// load_ready only in IDLE or on the last-bit strobe, so back-to-back words stream with no gap bit.
module serial_bit_feeder
   import fsm_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   serial_bit_feeder_if.slave  bus
);
   localparam int CW = CNT_W(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          done_q, done_nxt;
   logic          sr_load, sr_shift, sr_clr;
   logic          accept;

   // Ready is masked during reset so nothing is taken while the block is held.
   assign bus.load_ready = reset &&
                           ((state == ST_IDLE) ||
                            ((cnt == LAST) && bus.shift_en));
   assign accept = bus.load_valid && bus.load_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      sr_load   = 1'b0;
      sr_shift  = 1'b0;
      sr_clr    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               sr_load   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (bus.shift_en) begin
               if (cnt == LAST) begin
                  done_nxt = 1'b1;
                  cnt_nxt  = '0;
                  if (accept) begin
                     sr_load = 1'b1;
                  end else begin
                     sr_clr    = 1'b1;
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  sr_shift = 1'b1;
                  cnt_nxt  = cnt + CW'(1);
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   piso_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_sreg (
      .clk     (clk),
      .reset   (reset),
      .clr     (sr_clr),
      .load    (sr_load),
      .shift   (sr_shift),
      .data    (bus.load_data),
      .ser_out (bus.x_out)
   );

   assign bus.x_valid = (state == ST_SHIFT);
   assign bus.busy    = (state == ST_SHIFT);
   assign bus.done    = done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Drives identical stimulus into an MSB-first and an LSB-first feeder and scoreboards both serial streams.
module tb_serial_bit_feeder;

   typedef struct {
      logic msb_bit;
      logic lsb_bit;
      logic last;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       lv = 1'b0;
   logic [7:0] ld = 8'h00;
   logic       se = 1'b0;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t q[$];
   logic done_pend = 1'b0;

   serial_bit_feeder_if #(.WIDTH(8)) bm ();
   serial_bit_feeder_if #(.WIDTH(8)) bl ();

   assign bm.load_valid = lv;
   assign bm.load_data  = ld;
   assign bm.shift_en   = se;
   assign bl.load_valid = lv;
   assign bl.load_data  = ld;
   assign bl.shift_en   = se;

   serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(bm));
   serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(bl));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait for the handshake to complete, then return 1 time unit after the accept edge.
   task automatic wait_accept(input string tag);
      int n = 0;
      @(negedge clk);
      while (bm.load_ready !== 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: load_ready observed 0 for 40 cycles expected 1", tag);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_clear(input string tag);
      chk({tag, "_xout_m"},  {31'd0, bm.x_out},      32'd0);
      chk({tag, "_xout_l"},  {31'd0, bl.x_out},      32'd0);
      chk({tag, "_xvld_m"},  {31'd0, bm.x_valid},    32'd0);
      chk({tag, "_xvld_l"},  {31'd0, bl.x_valid},    32'd0);
      chk({tag, "_busy_m"},  {31'd0, bm.busy},       32'd0);
      chk({tag, "_done_m"},  {31'd0, bm.done},       32'd0);
      chk({tag, "_done_l"},  {31'd0, bl.done},       32'd0);
      chk({tag, "_rdy_m"},   {31'd0, bm.load_ready}, 32'd0);
      chk({tag, "_rdy_l"},   {31'd0, bl.load_ready}, 32'd0);
   endtask

   // Scoreboard monitor: checks outputs against the queue head, consumes on strobes, loads on accept.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         logic ev;
         logic eb_m;
         logic eb_l;
         exp_t e;
         ev   = (q.size() > 0);
         eb_m = ev ? q[0].msb_bit : 1'b0;
         eb_l = ev ? q[0].lsb_bit : 1'b0;
         chk("done_m",  {31'd0, bm.done},    {31'd0, done_pend});
         chk("done_l",  {31'd0, bl.done},    {31'd0, done_pend});
         chk("xvld_m",  {31'd0, bm.x_valid}, {31'd0, ev});
         chk("xvld_l",  {31'd0, bl.x_valid}, {31'd0, ev});
         chk("busy_m",  {31'd0, bm.busy},    {31'd0, ev});
         chk("busy_l",  {31'd0, bl.busy},    {31'd0, ev});
         chk("xout_m",  {31'd0, bm.x_out},   {31'd0, eb_m});
         chk("xout_l",  {31'd0, bl.x_out},   {31'd0, eb_l});
         done_pend = 1'b0;
         if (se && ev) begin
            e = q.pop_front();
            done_pend = e.last;
         end
         if (lv && bm.load_ready === 1'b1) begin
            for (int k = 0; k < 8; k++) begin
               e.msb_bit = ld[7-k];
               e.lsb_bit = ld[k];
               e.last    = (k == 7);
               q.push_back(e);
            end
         end
      end
   end

   initial begin
      // Reset held with random inputs: everything quiet, not ready.
      for (int i = 0; i < 5; i++) begin
         lv = 1'($urandom);
         ld = 8'($urandom);
         se = 1'($urandom);
         @(negedge clk);
         chk_all_clear("rst");
         step();
      end
      lv = 1'b0;
      se = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_rel_rdy_m", {31'd0, bm.load_ready}, 32'd1);
      chk("rst_rel_rdy_l", {31'd0, bl.load_ready}, 32'd1);
      step();

      // Single word, strobe always on.
      lv = 1'b1; ld = 8'hB4; se = 1'b1;
      wait_accept("acc_b4");
      lv = 1'b0;
      repeat (11) step();
      chk("drain_b4", q.size(), 32'd0);

      // Gapless stream: FF immediately followed by 00.
      lv = 1'b1; ld = 8'hFF;
      wait_accept("acc_ff");
      ld = 8'h00;
      wait_accept("acc_00");
      lv = 1'b0;
      repeat (11) step();
      chk("drain_gapless", q.size(), 32'd0);

      // Stalled strobe 1,0,0,1 ...; ready must stay low on stall cycles mid-word.
      se = 1'b0; lv = 1'b1; ld = 8'hC3;
      wait_accept("acc_c3");
      lv = 1'b0;
      begin
         int strb = 0;
         for (int i = 0; i < 32; i++) begin
            se = ((i % 4) == 0) || ((i % 4) == 3);
            @(negedge clk);
            if (!se && strb < 8) chk("rdy_mid", {31'd0, bm.load_ready}, 32'd0);
            if (se) strb++;
            @(posedge clk);
            #1;
         end
      end
      chk("drain_stall", q.size(), 32'd0);

      // Reset mid-word after 3 bits of A5, then 5A must serialize from its first bit.
      se = 1'b1; lv = 1'b1; ld = 8'hA5;
      wait_accept("acc_a5");
      lv = 1'b0;
      repeat (3) step();
      #2;
      reset = 1'b0;
      q.delete();
      done_pend = 1'b0;
      #1;
      chk_all_clear("midrst");
      step();
      reset = 1'b1;
      step();
      lv = 1'b1; ld = 8'h5A;
      wait_accept("acc_5a");
      lv = 1'b0;
      repeat (11) step();
      chk("drain_5a", q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation observed no end expected finish");
      $fatal(1, "timeout");
   end

endmodule
